// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational RV32 ALU
module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [2:0]      req0_uop,
  input  logic            req0_f7,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp0_zero,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [2:0]      req1_uop,
  input  logic            req1_f7,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic            rsp1_zero,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_uop,
  output logic            alu_f7,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [2:0]      uop_q;
  logic            f7_q;
  logic            owner_q;
  logic            last_grant_q;
  logic [XLEN-1:0] data_q;
  logic            zero_q;
  logic            grant0;
  logic            grant1;

  // Pick a winner among the current requesters; on a tie round-robin favours the port not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN && !last_grant_q) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // Next-state and handshake/ALU drive; ready is held low while reset is asserted.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_uop    = 3'b000;
    alu_f7     = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        if (grant0 || grant1) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op1   = op1_q;
        alu_op2   = op2_q;
        alu_uop   = uop_q;
        alu_f7    = f7_q;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch on acceptance, result capture at the end of the ALU cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op1_q        <= '0;
      op2_q        <= '0;
      uop_q        <= 3'b000;
      f7_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      zero_q       <= 1'b0;
    end else begin
      if (state == S_IDLE && (grant0 || grant1)) begin
        op1_q        <= grant1 ? req1_op1 : req0_op1;
        op2_q        <= grant1 ? req1_op2 : req0_op2;
        uop_q        <= grant1 ? req1_uop : req0_uop;
        f7_q         <= grant1 ? req1_f7  : req0_f7;
        owner_q      <= grant1;
        last_grant_q <= grant1;
      end
      if (state == S_EXEC) begin
        data_q <= alu_out;
        zero_q <= alu_zero;
      end
    end
  end

  assign rsp0_data = data_q;
  assign rsp1_data = data_q;
  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (round-robin and fixed-priority instances)
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_uop, req1_uop;
  logic        req0_f7, req1_f7;

  // instance 0: RR_EN=1, instance 1: RR_EN=0; both see identical inputs
  logic        r0 [2];
  logic        r1 [2];
  logic        v0 [2];
  logic        v1 [2];
  logic [31:0] d0 [2];
  logic [31:0] d1 [2];
  logic        z0 [2];
  logic        z1 [2];
  logic [31:0] aop1 [2];
  logic [31:0] aop2 [2];
  logic [2:0]  auop [2];
  logic        af7 [2];
  logic [31:0] aout [2];
  logic        azero [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] u, input logic f);
    case (u)
      3'd0:    return f ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return f ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.XLEN(32), .RR_EN(g == 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(r0[g]), .req0_op1(req0_op1), .req0_op2(req0_op2),
      .req0_uop(req0_uop), .req0_f7(req0_f7),
      .rsp0_valid(v0[g]), .rsp0_ready(rsp0_ready), .rsp0_data(d0[g]), .rsp0_zero(z0[g]),
      .req1_valid(req1_valid), .req1_ready(r1[g]), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .req1_uop(req1_uop), .req1_f7(req1_f7),
      .rsp1_valid(v1[g]), .rsp1_ready(rsp1_ready), .rsp1_data(d1[g]), .rsp1_zero(z1[g]),
      .alu_op1(aop1[g]), .alu_op2(aop2[g]), .alu_uop(auop[g]), .alu_f7(af7[g]),
      .alu_out(aout[g]), .alu_zero(azero[g])
    );
    assign aout[g]  = alu_ref(aop1[g], aop2[g], auop[g], af7[g]);
    assign azero[g] = (aout[g] == 32'h0);
  end

  // transaction model: phase 0 free, 1 computing, 2 result pending
  int          ph [2]   = '{0, 0};
  int          own [2]  = '{0, 0};
  int          last [2] = '{1, 1};
  logic [31:0] mdata [2] = '{32'h0, 32'h0};
  logic        mzero [2] = '{1'b0, 1'b0};
  logic [31:0] lop1 [2] = '{32'h0, 32'h0};
  logic [31:0] lop2 [2] = '{32'h0, 32'h0};
  logic [2:0]  luop [2] = '{3'h0, 3'h0};
  logic        lf7 [2]  = '{1'b0, 1'b0};

  function automatic int pick(input int i);
    if (req0_valid && req1_valid) return (i == 0 && last[i] == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i] <= 0; last[i] <= 1; mdata[i] <= 32'h0; mzero[i] <= 1'b0;
      end else if (ph[i] == 0) begin
        if (pick(i) >= 0) begin
          ph[i]   <= 1;
          own[i]  <= pick(i);
          last[i] <= pick(i);
          lop1[i] <= (pick(i) == 1) ? req1_op1 : req0_op1;
          lop2[i] <= (pick(i) == 1) ? req1_op2 : req0_op2;
          luop[i] <= (pick(i) == 1) ? req1_uop : req0_uop;
          lf7[i]  <= (pick(i) == 1) ? req1_f7  : req0_f7;
        end
      end else if (ph[i] == 1) begin
        mdata[i] <= alu_ref(lop1[i], lop2[i], luop[i], lf7[i]);
        mzero[i] <= (alu_ref(lop1[i], lop2[i], luop[i], lf7[i]) == 32'h0);
        ph[i]    <= 2;
      end else if ((own[i] == 0 && rsp0_ready) || (own[i] == 1 && rsp1_ready)) begin
        ph[i] <= 0;
      end
    end
  end

  // hand-computed expectations set by the stimulus for the current cycle
  logic        pin_on [2];
  logic [3:0]  pin_hs [2];
  logic        pin_dchk [2];
  logic [31:0] pin_data [2];
  logic        pin_z [2];
  logic        pin_a0 [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  hs;
      logic [3:0]  ehs;
      logic [67:0] alu_act;
      logic [67:0] alu_exp;
      hs      = {r0[i], r1[i], v0[i], v1[i]};
      ehs     = {rst_n && ph[i] == 0 && pick(i) == 0, rst_n && ph[i] == 0 && pick(i) == 1,
                 ph[i] == 2 && own[i] == 0, ph[i] == 2 && own[i] == 1};
      alu_act = {aop1[i], aop2[i], auop[i], af7[i]};
      alu_exp = (ph[i] == 1) ? {lop1[i], lop2[i], luop[i], lf7[i]} : 68'h0;
      chk("model_handshake", i, 68'(hs), 68'(ehs));
      chk("model_rsp0_data", i, 68'(d0[i]), 68'(mdata[i]));
      chk("model_rsp1_data", i, 68'(d1[i]), 68'(mdata[i]));
      chk("model_zero", i, 68'({z0[i], z1[i]}), 68'({mzero[i], mzero[i]}));
      chk("model_alu", i, alu_act, alu_exp);
      if (pin_on[i]) chk("pin_handshake", i, 68'(hs), 68'(pin_hs[i]));
      if (pin_dchk[i]) begin
        chk("pin_data", i, 68'({d0[i], d1[i]}), 68'({pin_data[i], pin_data[i]}));
        chk("pin_zero", i, 68'({z0[i], z1[i]}), 68'({pin_z[i], pin_z[i]}));
      end
      if (pin_a0[i]) chk("pin_alu_idle", i, alu_act, 68'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      pin_on[i] = 1'b0; pin_dchk[i] = 1'b0; pin_a0[i] = 1'b0;
    end
  endtask

  task automatic pin(input int i, input logic [3:0] hs);
    pin_on[i] = 1'b1;
    pin_hs[i] = hs;
  endtask

  task automatic pin_both(input logic [3:0] hs);
    pin(0, hs);
    pin(1, hs);
  endtask

  task automatic pin_d(input logic [31:0] d, input logic z);
    for (int i = 0; i < 2; i++) begin
      pin_dchk[i] = 1'b1; pin_data[i] = d; pin_z[i] = z;
    end
  endtask

  task automatic pin_idle_alu();
    pin_a0[0] = 1'b1;
    pin_a0[1] = 1'b1;
  endtask

  function automatic logic [3:0] rr_hs(input int m, input int o);
    if (m == 0) return (o == 1) ? 4'b0100 : 4'b1000;
    if (m == 2) return (o == 1) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      pin_on[i] = 1'b0; pin_hs[i] = 4'h0; pin_dchk[i] = 1'b0;
      pin_data[i] = 32'h0; pin_z[i] = 1'b0; pin_a0[i] = 1'b0;
    end
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'h0; req0_op2 = 32'h0; req0_uop = 3'd0; req0_f7 = 1'b0;
    req1_valid = 1'b0; req1_op1 = 32'h0; req1_op2 = 32'h0; req1_uop = 3'd0; req1_f7 = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // reset cycle: ready stays low even with a valid request
    step();
    pin_both(4'b0000); pin_d(32'h0, 1'b0); pin_idle_alu();
    step();
    rst_n = 1'b1; req0_valid = 1'b0;
    pin_both(4'b0000); pin_d(32'h0, 1'b0); pin_idle_alu();
    step();

    // port 0 alone: 5 + 7
    req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_uop = 3'd0; req0_f7 = 1'b0;
    pin_both(4'b1000);
    step();
    req0_valid = 1'b0; pin_both(4'b0000);
    step();
    pin_both(4'b0010); pin_d(32'd12, 1'b0);
    step();

    // port 1 alone: x - x gives zero
    req1_valid = 1'b1; req1_op1 = 32'h1234; req1_op2 = 32'h1234; req1_uop = 3'd0; req1_f7 = 1'b1;
    pin_both(4'b0100);
    step();
    req1_valid = 1'b0; pin_both(4'b0000);
    step();
    pin_both(4'b0001); pin_d(32'h0, 1'b1);
    step();

    // both valid continuously: RR alternates 0,1,0,1; fixed priority always port 0
    req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd3; req0_uop = 3'd0; req0_f7 = 1'b0;
    req1_valid = 1'b1; req1_op1 = 32'd10; req1_op2 = 32'd3; req1_uop = 3'd0; req1_f7 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pin(0, rr_hs(k % 3, (k / 3) % 2));
      pin(1, rr_hs(k % 3, 0));
      if (k % 3 == 2) begin
        pin_dchk[0] = 1'b1; pin_data[0] = ((k / 3) % 2 == 1) ? 32'd7 : 32'd13; pin_z[0] = 1'b0;
        pin_dchk[1] = 1'b1; pin_data[1] = 32'd13; pin_z[1] = 1'b0;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'h8000_0000; req0_op2 = 32'd4; req0_uop = 3'd5; req0_f7 = 1'b1;
    req1_valid = 1'b1; req1_op1 = 32'd9; req1_op2 = 32'd2; req1_uop = 3'd4; req1_f7 = 1'b0;
    pin_both(4'b1000);
    step();
    req0_valid = 1'b0; pin_both(4'b0000);
    step();
    for (int k = 0; k < 5; k++) begin
      pin_both(4'b0010); pin_d(32'hF800_0000, 1'b0);
      step();
    end
    rsp0_ready = 1'b1;
    pin_both(4'b0010); pin_d(32'hF800_0000, 1'b0);
    step();
    pin_both(4'b0100);
    step();
    req1_valid = 1'b0; pin_both(4'b0000);
    step();
    pin_both(4'b0001); pin_d(32'd11, 1'b0);
    step();

    // reset during the ALU cycle of a port 1 request
    req1_valid = 1'b1; req1_op1 = 32'h55; req1_op2 = 32'h0F; req1_uop = 3'd7; req1_f7 = 1'b0;
    pin_both(4'b0100);
    step();
    req1_valid = 1'b0; rst_n = 1'b0; pin_both(4'b0000);
    step();
    rst_n = 1'b1;
    pin_both(4'b0000); pin_d(32'h0, 1'b0); pin_idle_alu();
    step();
    req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd4; req0_uop = 3'd0; req0_f7 = 1'b0;
    req1_valid = 1'b1;
    pin_both(4'b1000);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; pin_both(4'b0000);
    step();
    pin_both(4'b0010); pin_d(32'd7, 1'b0);
    step();

    // idle: nothing moves for 10 cycles
    for (int k = 0; k < 10; k++) begin
      pin_both(4'b0000); pin_idle_alu();
      step();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational RV32 ALU between two requesters: port 0 (execute stage) and port 1 (CSR/AMO helper unit).
- Arbitrates, latches the winner's operands, drives the ALU for one cycle, and registers the result.
- Holds the registered result on the winner's response channel until it is accepted.
- Sits between the requesters and the ALU instance; the ALU's own reset input is tied to the same rst_n.

Parameters:
XLEN, 32, operand/result width
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op1  in  XLEN  port 0 operand 1
req0_op2  in  XLEN  port 0 operand 2
req0_uop  in  3  port 0 ALU funct3
req0_f7  in  1  port 0 SUB/SRA select
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 result accepted
rsp0_data  out  XLEN  port 0 result
rsp0_zero  out  1  port 0 result-is-zero flag
req1_*/rsp1_*  same set as port 0, for port 1
alu_op1  out  XLEN  to ALU op1
alu_op2  out  XLEN  to ALU op2
alu_uop  out  3  to ALU uop
alu_f7  out  1  to ALU f7
alu_out  in  XLEN  from ALU result
alu_zero  in  1  from ALU zero flag

Behaviour:
- FSM states:
  - IDLE: req_ready may assert.
  - EXEC: ALU driven from the operand registers.
  - RESP: rsp_valid held.
- IDLE:
  - reqX_ready = grantX combinationally; ready is never asserted without the matching valid.
  - On any valid: latch op1/op2/uop/f7 and the owner index; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs = latched operands.
  - At the end of the cycle, capture alu_out into rsp_data and alu_zero into rsp_zero; go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other port's rsp_valid = 0.
  - On rsp<owner>_ready = 1: go to IDLE.
  - rsp_data/rsp_zero stay stable while valid.
- alu_* outputs are 0 in IDLE and RESP.
- Latency: request accepted at edge N; rsp_valid high in cycle N+2. Minimum 3 cycles per transaction.
- Arbitration:
  - RR_EN=1: a single valid wins. If both are valid, the port not granted last wins. The last_grant register updates only on acceptance.
  - RR_EN=0: port 0 wins any tie.
- Requests not granted are not consumed; the requester holds valid and operands stable until ready.
- No new request is accepted while in EXEC or RESP; both req_ready = 0 there.
- Response channels are shared internally; rsp_data/rsp_zero are driven to both ports, but only the owner's valid asserts.
- Reset, including mid-transaction:
  - State = IDLE; in-flight transaction dropped, no response issued.
  - rsp*_valid = 0, rsp*_data = 0, rsp*_zero = 0.
  - req*_ready = 0 during the reset cycle.
  - alu_* = 0.
  - last_grant = port 1, so port 0 wins the first tie after reset.
- The arbiter does no width or arithmetic processing; the result is the ALU's 32-bit output verbatim. Shift masking and signedness are the ALU's responsibility.

Test Plan:
- Port 0 only: op1=5, op2=7, uop=000, f7=0 → req0_ready high one cycle; 2 cycles later rsp0_valid=1, rsp0_data=12, rsp0_zero=0; rsp1_valid stays 0.
- Port 1 only: op1=0x1234, op2=0x1234, uop=000, f7=1 → rsp1_data=0, rsp1_zero=1.
- Both valid continuously, RR_EN=1, responses acked immediately → grants alternate 0,1,0,1 over 4 transactions, with a new grant every 3 cycles. Repeat with RR_EN=0 → all grants go to port 0.
- Backpressure: port 0 request op1=0x80000000, op2=4, uop=101, f7=1, with rsp0_ready low for 5 cycles → rsp0_valid/rsp0_data=0xF8000000 held stable. Port 1 request pending throughout with req1_ready=0; port 1 is granted in the cycle after the ack.
- Reset asserted during EXEC of a port 1 request → next cycle all outputs are 0 and no rsp1_valid ever appears for it. After release with both valid, port 0 is granted first.
- Idle check: no valids → alu_op1/op2/uop/f7 = 0 and all ready/valid outputs stay 0 for 10 cycles.
